// File: rtl/sum_display_driver.sv
// Binary-to-BCD sum display driver: double-dabble converter plus a 4-digit multiplexed scanner.
// Optional macro SUM_DISPLAY_LZB_EN enables leading-zero blanking on the digit output.
module sum_display_driver #(
  parameter int BIN_W       = 14,
  parameter int REFRESH_CNT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       digit,
  output logic [3:0]       an
);

  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam int REF_W  = $clog2(REFRESH_CNT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       disp_q, disp_d;
  logic [REF_W-1:0]  refresh_q, refresh_d;
  logic [1:0]        scan_q, scan_d;
  logic [3:0]        digit_q, digit_d;
  logic [3:0]        an_q, an_d;
  logic              over_range;
  logic              wrap;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Blanked nibbles become 4'hF, which the downstream decoder renders dark.
  function automatic logic [3:0] pick_digit(input logic [15:0] disp, input logic [1:0] idx);
    logic [3:0] nib;
    logic       blank;
    blank = 1'b0;
    case (idx)
      2'd0:    nib = disp[3:0];
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = disp[15:12];
    endcase
`ifdef SUM_DISPLAY_LZB_EN
    case (idx)
      2'd1:    blank = (disp[15:4] == 12'h000);
      2'd2:    blank = (disp[15:8] == 8'h00);
      2'd3:    blank = (disp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    return blank ? 4'hF : nib;
  endfunction

  assign over_range = (32'(bin_in) > 32'd9999);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (over_range) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            ovf_d   = 1'b0;
            bin_d   = bin_in;
            bcd_d   = 16'h0000;
            iter_d  = ITER_W'(BIN_W);
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        // The top nibble of a valid 4-digit result never exceeds 9, so its carry bit is dropped.
        bcd_d  = {3'(add3(bcd_q[15:12])), add3(bcd_q[11:8]), add3(bcd_q[7:4]),
                  add3(bcd_q[3:0]), bin_q[BIN_W-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q - ITER_W'(1);
        if (iter_q == ITER_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_d  = ovf_q ? 16'hFFFF : bcd_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // The scanner reads the display register from before the edge, so a fresh value lands one cycle later.
  always_comb begin
    wrap      = (refresh_q == REF_W'(REFRESH_CNT - 1));
    refresh_d = wrap ? '0 : refresh_q + REF_W'(1);
    scan_d    = wrap ? scan_q + 2'd1 : scan_q;
    digit_d   = pick_digit(disp_q, scan_d);
    an_d      = ~(4'b0001 << scan_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= 16'h0000;
      iter_q    <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      disp_q    <= 16'h0000;
      refresh_q <= '0;
      scan_q    <= 2'd0;
      digit_q   <= 4'd0;
      an_q      <= 4'b1110;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      disp_q    <= disp_d;
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign digit = digit_q;
  assign an    = an_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver: directed loads plus random traffic against a decimal reference model.
module tb_sum_display_driver;

  localparam int BIN_W = 14;
  localparam int REF   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, ovf;
  logic [3:0]       digit, an;

  int checks = 0;
  int errors = 0;

  // Reference model: displayed value as a plain integer (-1 means overflow), cycles left until done.
  int n_edges   = 0;
  int m_disp    = 0;
  int prev_disp = 0;
  int m_rem     = 0;
  int m_pending = 0;
  int m_ovf     = 0;
  int m_done    = 0;

  sum_display_driver #(.BIN_W(BIN_W), .REFRESH_CNT(REF)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .digit(digit), .an(an)
  );

  always #5 clk = ~clk;

  function automatic int exp_digit(int v, int idx);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (v < 0) return 15;
`ifdef SUM_DISPLAY_LZB_EN
    if (idx > 0 && v < p) return 15;
`endif
    return (v / p) % 10;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    n_edges   = 0;
    m_disp    = 0;
    prev_disp = 0;
    m_rem     = 0;
    m_ovf     = 0;
    m_done    = 0;
  endtask

  task automatic modelEdge(input bit ld, input int val);
    bit was_busy;
    was_busy  = (m_rem > 0);
    n_edges++;
    prev_disp = m_disp;
    m_done    = 0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_disp = m_pending;
        m_done = 1;
      end
    end
    if (ld && !was_busy) begin
      if (val > 9999) begin
        m_ovf = 1; m_pending = -1; m_rem = 1;
      end else begin
        m_ovf = 0; m_pending = val; m_rem = BIN_W + 1;
      end
    end
  endtask

  task automatic checkAll();
    int idx;
    idx = (n_edges / REF) % 4;
    checkOutput("busy", int'(busy), (m_rem > 0) ? 1 : 0);
    checkOutput("done", int'(done), m_done);
    checkOutput("ovf", int'(ovf), m_ovf);
    checkOutput("digit", int'(digit), exp_digit(prev_disp, idx));
    checkOutput("an", int'(an), (~(1 << idx)) & 15);
  endtask

  task automatic applyStimulus(input bit ld, input int val);
    load   = ld;
    bin_in = BIN_W'(val);
    @(posedge clk);
    modelEdge(ld, val);
    #1;
    checkAll();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_ovf"}, int'(ovf), 0);
    checkOutput({tag, "_digit"}, int'(digit), 0);
    checkOutput({tag, "_an"}, int'(an), 14);
  endtask

  initial begin
    int val;
    bit ld;
    #12;
    checkResetState("rst0");
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    $display("[TB] idle scan");
    idleCycles(20);

    $display("[TB] load 1234");
    applyStimulus(1'b1, 1234);
    idleCycles(40);

    $display("[TB] load 9999 then 10000");
    applyStimulus(1'b1, 9999);
    idleCycles(30);
    applyStimulus(1'b1, 10000);
    idleCycles(20);

    $display("[TB] load 42 with ignored load mid-conversion");
    applyStimulus(1'b1, 42);
    idleCycles(4);
    applyStimulus(1'b1, 5555);
    idleCycles(40);

    $display("[TB] load 8765 then reset mid-conversion");
    applyStimulus(1'b1, 8765);
    idleCycles(6);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("rst_conv");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    idleCycles(30);

    $display("[TB] small values 7, 0, 1005");
    applyStimulus(1'b1, 7);
    idleCycles(30);
    applyStimulus(1'b1, 0);
    idleCycles(30);
    applyStimulus(1'b1, 1005);
    idleCycles(30);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) val = int'($urandom_range(10000, 16383));
      else val = int'($urandom_range(0, 9999));
      applyStimulus(ld, val);
    end
    idleCycles(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
